board_input_debounce: RTL and testbench
=======================================

# board_input_debounce

Conditions raw asynchronous board inputs (centre push-button and slide switches) before they reach the sigma SoC's `irq_btn_i` and `gpio_bi` inputs. Each input gets a two-flop synchronizer and a per-input stability counter, and produces a clean debounced level. The block also emits single-cycle press, release and change pulses. It sits in the board top between the pads and the `sigma` instance, clocked by the PLL output clock.

## Interface

Parameters:
- `SW_WIDTH`, 16: number of slide-switch inputs.
- `STABLE_CYCLES`, 500000: consecutive clock cycles a synchronized input must differ from the debounced state before the state flips. Legal range is 2 or more.
- `CNT_WIDTH`, $clog2(STABLE_CYCLES): stability counter width, derived. Not to be overridden.

Ports (reset is asynchronous, active-low):
- `clk_i`  in  1  system clock (PLL output).
- `arst_n_i`  in  1  asynchronous active-low reset. Top level drives it with `CPU_RESETN & pll_locked`.
- `btn_i`  in  1  raw push-button, asynchronous.
- `sw_i`  in  SW_WIDTH  raw switches, asynchronous.
- `btn_o`  out  1  debounced button level.
- `btn_press_o`  out  1  one-cycle pulse on debounced 0->1.
- `btn_release_o`  out  1  one-cycle pulse on debounced 1->0.
- `sw_o`  out  SW_WIDTH  debounced switch levels.
- `sw_change_o`  out  1  one-cycle pulse when any bit of `sw_o` changes.

## Operation

- Channels: there are SW_WIDTH+1 identical channels (button plus each switch). Each channel has sync1, sync2, state, and cnt[CNT_WIDTH-1:0].
- Synchronizer, every cycle: sync1 <= raw; sync2 <= sync1.
- Stability counter, one case per cycle:
  - If sync2 == state: cnt <= 0.
  - If sync2 != state and cnt != STABLE_CYCLES-1: cnt <= cnt+1.
  - If sync2 != state and cnt == STABLE_CYCLES-1: state <= sync2 and cnt <= 0.
- Glitch rejection: any cycle in which sync2 returns to state clears cnt. A bounce shorter than STABLE_CYCLES consecutive cycles therefore never reaches the output. The counter never wraps.
- Level outputs: `btn_o` and `sw_o` are the state registers directly.
- Pulse registers:
  - `btn_press_o` is high exactly in the first cycle `btn_o` reads 1.
  - `btn_release_o` is high exactly in the first cycle `btn_o` reads 0.
  - `sw_change_o` is high in the first cycle of any updated `sw_o` value.
  - Each pulse is registered alongside its state update and deasserts the following cycle.
- Simultaneous events:
  - Several switch bits flipping on the same cycle produce a single `sw_change_o` pulse.
  - Button and switch flips on the same cycle each produce their own pulses.
  - Flips on consecutive cycles produce back-to-back pulses (two cycles high).
- Reset:
  - `arst_n_i` low immediately clears all sync, state, cnt and pulse registers, including mid-count.
  - After reset, all outputs are 0.
  - An input already held high at reset release is treated as a normal 0->1 transition. It produces a press pulse (button) or a change pulse (switches).

## Timing

- Reset value of every output is 0.
- Latency: the raw input changes and stays stable before clock edge E. The debounced output changes at edge E+1+STABLE_CYCLES, i.e. it is visible in cycle E+1+STABLE_CYCLES.
  - 2 cycles come from synchronization (sync2 shows the new value after E+1).
  - STABLE_CYCLES cycles come from counting.
- The pulse coincides with the first cycle of the new output level.
- Minimum accepted pulse width on a raw input is STABLE_CYCLES cycles, measured at sync2.
- Channels are fully independent. No shared prescaler, so there is no cross-channel phase dependency.
- Each output is driven by a single flop; no combinational path from inputs to outputs.

## Test plan

Bench parameters: STABLE_CYCLES=8, SW_WIDTH=16.

- Clean press: `btn_i` 0->1 before edge 10 and held.
  - `btn_o`=1 from cycle 19 onward.
  - `btn_press_o`=1 only in cycle 19.
  - Releasing later gives a one-cycle `btn_release_o` 9 cycles after the release edge.
- Bounce rejection: `btn_i` toggles high 5 cycles, low 2, high 7, low.
  - `btn_o` stays 0 and no pulses.
  - Then held high 20 cycles: exactly one press pulse, 9 cycles after the final rising edge.
- Multi-switch: `sw_i`=16'h00F0 applied at once.
  - `sw_o`=16'h00F0 after 9 cycles, with a single `sw_change_o` pulse.
  - Then bit 0 flips alone: `sw_o`=16'h00F1 and a second single pulse.
- Reset mid-count: `btn_i` held high, `arst_n_i` dropped when cnt=5.
  - All outputs 0 immediately.
  - After release, the press appears 9 cycles after the first post-reset edge.
- Power-up high: `sw_i`=16'hFFFF and `btn_i`=1 held through reset.
  - After release, `sw_o`=16'hFFFF and `btn_o`=1 in the same cycle.
  - That cycle has one `sw_change_o` pulse and one `btn_press_o` pulse.
- Counter saturation: `btn_i` held high for 1000 cycles.
  - Exactly one press pulse; cnt stays 0 after the flip.
  - No spurious re-toggle.

Source files
------------

// File: rtl/board_input_debounce.sv
// Debounces the raw board push-button and slide switches: two-flop synchronizer plus a
// per-channel stability counter, with registered press/release/change pulses.
module board_input_debounce #(
  parameter int SW_WIDTH      = 16,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES)
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                btn_o,
  output logic                btn_press_o,
  output logic                btn_release_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                sw_change_o
);

  // Channel 0 is the button, channels 1..SW_WIDTH are the switches.
  localparam int                   N_CH     = SW_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [N_CH-1:0]                raw;
  logic [N_CH-1:0]                sync1;
  logic [N_CH-1:0]                sync2;
  logic [N_CH-1:0]                state;
  logic [N_CH-1:0]                state_next;
  logic [N_CH-1:0][CNT_WIDTH-1:0] cnt;
  logic [N_CH-1:0][CNT_WIDTH-1:0] cnt_next;

  logic btn_press_q;
  logic btn_release_q;
  logic sw_change_q;

  assign raw = {sw_i, btn_i};

  // Any cycle where sync2 agrees with state restarts the count, so only an
  // uninterrupted run of STABLE_CYCLES disagreeing cycles flips the state.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    cnt_next   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2[i] != state[i]) begin
        if (cnt[i] == CNT_LAST) begin
          state_next[i] = sync2[i];
          cnt_next[i]   = '0;
        end else begin
          cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
      state <= '0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking so sync2 takes last cycle's sync1, giving a true two-flop chain.
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Pulses are registered from the same next-state decision, so they line up
  // with the first cycle of the new level.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_press_q   <= 1'b0;
      btn_release_q <= 1'b0;
      sw_change_q   <= 1'b0;
    end else begin
      btn_press_q   <= state_next[0] & ~state[0];
      btn_release_q <= ~state_next[0] & state[0];
      sw_change_q   <= |(state_next[N_CH-1:1] ^ state[N_CH-1:1]);
    end
  end

  assign btn_o         = state[0];
  assign sw_o          = state[N_CH-1:1];
  assign btn_press_o   = btn_press_q;
  assign btn_release_o = btn_release_q;
  assign sw_change_o   = sw_change_q;

endmodule

// File: tb/tb_board_input_debounce.sv
// Directed bench for board_input_debounce with STABLE_CYCLES=8: outputs are packed as
// {btn_o, btn_press_o, btn_release_o, sw_change_o, sw_o} and compared cycle by cycle.
module tb_board_input_debounce;

  localparam int SW_WIDTH      = 16;
  localparam int STABLE_CYCLES = 8;
  // Input applied before edge E flips the output at edge E+1+STABLE_CYCLES, i.e. step 10.
  localparam int LAT           = STABLE_CYCLES + 2;

  logic                clk      = 1'b0;
  logic                arst_n_i = 1'b0;
  logic                btn_i    = 1'b0;
  logic [SW_WIDTH-1:0] sw_i     = '0;
  logic                btn_o;
  logic                btn_press_o;
  logic                btn_release_o;
  logic [SW_WIDTH-1:0] sw_o;
  logic                sw_change_o;

  int checks = 0;
  int errors = 0;

  logic [19:0] obs;
  logic [19:0] exp_v;
  assign obs = {btn_o, btn_press_o, btn_release_o, sw_change_o, sw_o};

  board_input_debounce #(
    .SW_WIDTH     (SW_WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n_i),
    .btn_i        (btn_i),
    .sw_i         (sw_i),
    .btn_o        (btn_o),
    .btn_press_o  (btn_press_o),
    .btn_release_o(btn_release_o),
    .sw_o         (sw_o),
    .sw_change_o  (sw_change_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n_i = 1'b0;
    btn_i    = 1'b0;
    sw_i     = '0;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_initial: outputs=%h expected %h", obs, 20'h0);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (obs !== 20'h0) begin
        errors++;
        $display("FAIL reset_hold c=%0d: outputs=%h expected %h", c, obs, 20'h0);
      end
    end
    arst_n_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (obs !== 20'h0) begin
        errors++;
        $display("FAIL reset_idle c=%0d: outputs=%h expected %h", c, obs, 20'h0);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_i = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      exp_v = {c >= LAT, c == LAT, 1'b0, 1'b0, 16'h0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
    btn_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {c < LAT, 1'b0, c == LAT, 1'b0, 16'h0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_release c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    int seg_len [4] = '{5, 2, 7, 4};
    for (int s = 0; s < 4; s++) begin
      btn_i = (s % 2 == 0);
      for (int c = 1; c <= seg_len[s]; c++) begin
        step();
        checks++;
        if (obs !== 20'h0) begin
          errors++;
          $display("FAIL bounce seg=%0d c=%0d: outputs=%h expected %h", s, c, obs, 20'h0);
        end
      end
    end
    btn_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_v = {c >= LAT, c == LAT, 1'b0, 1'b0, 16'h0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_hold c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
    btn_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {c < LAT, 1'b0, c == LAT, 1'b0, 16'h0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_release c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_multi_switch();
    sw_i = 16'h00F0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {1'b0, 1'b0, 1'b0, c == LAT, (c >= LAT) ? 16'h00F0 : 16'h0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL multi_switch c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
    sw_i = 16'h00F1;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {1'b0, 1'b0, 1'b0, c == LAT, (c >= LAT) ? 16'h00F1 : 16'h00F0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single_bit c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Button and switch bit 1 together: both pulses on the same cycle.
    btn_i = 1'b1;
    sw_i  = 16'h00F3;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {c >= LAT, c == LAT, 1'b0, c == LAT, (c >= LAT) ? 16'h00F3 : 16'h00F1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL btn_and_sw c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
    // Bit 2 then bit 3 one cycle apart: two adjacent change pulses.
    sw_i = 16'h00F7;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) sw_i = 16'h00FF;
      exp_v = {1'b1, 1'b0, 1'b0, (c == LAT) || (c == LAT + 1),
               (c < LAT) ? 16'h00F3 : (c == LAT) ? 16'h00F7 : 16'h00FF};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL back_to_back c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    btn_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {c < LAT, 1'b0, c == LAT, 1'b0, 16'h00FF};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pre_count_release c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
    btn_i = 1'b1;
    // Step 3 gives cnt=1, so step 7 leaves cnt=5.
    repeat (7) step();
    #2;
    arst_n_i = 1'b0;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_count_async: outputs=%h expected %h", obs, 20'h0);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (obs !== 20'h0) begin
        errors++;
        $display("FAIL reset_mid_count_hold c=%0d: outputs=%h expected %h", c, obs, 20'h0);
      end
    end
    arst_n_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {c >= LAT, c == LAT, 1'b0, c == LAT, (c >= LAT) ? 16'h00FF : 16'h0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset_press c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_power_up_high();
    arst_n_i = 1'b0;
    sw_i     = 16'hFFFF;
    btn_i    = 1'b1;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL power_up_in_reset: outputs=%h expected %h", obs, 20'h0);
    end
    repeat (2) step();
    arst_n_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {c >= LAT, c == LAT, 1'b0, c == LAT, (c >= LAT) ? 16'hFFFF : 16'h0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL power_up_high c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    int presses = 0;
    btn_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {c < LAT, 1'b0, c == LAT, 1'b0, 16'hFFFF};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sat_pre_release c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
    btn_i = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      step();
      if (btn_press_o === 1'b1) presses++;
      exp_v = {c >= LAT, c == LAT, 1'b0, 1'b0, 16'hFFFF};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL saturation c=%0d: outputs=%h expected %h", c, obs, exp_v);
      end
    end
    checks++;
    if (presses !== 1) begin
      errors++;
      $display("FAIL saturation_press_count: got %0d expected 1", presses);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_switch();
    test_back_to_back();
    test_reset_mid_count();
    test_power_up_high();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
